// File: rtl/fir_resampler_drain.sv
// Request pacer and output FIFO for a FIR resampler: phase-accumulator request ticks,
// credit flow control, response watchdog and drain-on-disable. Optional macro: FIR_RESAMPLER_DRAIN_STAT_EN.
module fir_resampler_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [ACC_WIDTH-1:0]         step_i,
  output logic                         rs_req_o,
  input  logic signed [DATA_WIDTH-1:0] rs_data_i,
  input  logic                         rs_val_i,
  output logic signed [DATA_WIDTH-1:0] m_data_o,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fill_o,
  output logic [2:0]                   err_flg_o,
  output logic [31:0]                  miss_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                       r_state;
  logic [ACC_WIDTH-1:0]         r_acc;
  logic [CW-1:0]                r_out;
  logic [CW-1:0]                r_fill;
  logic [PW-1:0]                r_wr_ptr;
  logic [PW-1:0]                r_rd_ptr;
  logic [WW-1:0]                r_wd;
  logic                         r_req;
  logic [2:0]                   r_err;
  logic signed [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic [ACC_WIDTH:0] w_sum;
  logic [CW:0]        w_used;
  logic               w_tick;
  logic               w_issue;
  logic               w_miss;
  logic               w_sol;
  logic               w_unsol;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_timeout;

  // Ticks are taken only when RUN persists into the next cycle, so a request never lands in DRAIN.
  always_comb begin
    w_sum     = {1'b0, r_acc} + {1'b0, step_i};
    w_used    = {1'b0, r_fill} + {1'b0, r_out};
    w_tick    = (r_state == RUN) && en_i && w_sum[ACC_WIDTH];
    w_issue   = w_tick && (w_used < (CW+1)'(FIFO_DEPTH));
    w_miss    = w_tick && !(w_used < (CW+1)'(FIFO_DEPTH));
    w_sol     = rs_val_i && (r_out != '0);
    w_unsol   = rs_val_i && (r_out == '0);
    w_full    = (r_fill == CW'(FIFO_DEPTH));
    w_pop     = m_valid_o && m_ready_i;
    w_push    = rs_val_i && (!w_full || w_pop);
    w_timeout = (r_out != '0) && !rs_val_i && (r_wd == WW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_req <= w_issue;
      unique case (r_state)
        IDLE: begin
          if (en_i) begin
            r_state <= RUN;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (!en_i) r_state <= DRAIN;
        end
        DRAIN: begin
          if (en_i) r_state <= RUN;
          else if (r_out == '0) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A timeout abandons every outstanding request; a request issued in that same cycle still counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
      r_wd  <= '0;
    end else begin
      if (w_timeout) r_out <= w_issue ? CW'(1) : '0;
      else if (w_issue && !w_sol) r_out <= r_out + 1'b1;
      else if (!w_issue && w_sol) r_out <= r_out - 1'b1;

      if (rs_val_i || (r_out == '0) || w_timeout) r_wd <= '0;
      else r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fill   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_fill <= r_fill + 1'b1;
      else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
      r_err <= r_err | {w_unsol, w_timeout, w_miss};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= rs_data_i;
  end

`ifdef FIR_RESAMPLER_DRAIN_STAT_EN
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_miss_cnt <= '0;
    else if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
  end

  assign miss_cnt_o = r_miss_cnt;
`else
  assign miss_cnt_o = '0;
`endif

  assign rs_req_o  = r_req;
  assign m_valid_o = (r_fill != '0);
  assign m_data_o  = m_valid_o ? r_mem[r_rd_ptr] : '0;
  assign fill_o    = r_fill;
  assign err_flg_o = r_err;

endmodule

// File: tb/tb_fir_resampler_drain.sv
// Scoreboard bench for fir_resampler_drain: a resampler model answers requests after a
// programmable latency; every answered sample is expected on the output stream in order.
module tb_fir_resampler_drain;

  logic        clk_i     = 1'b0;
  logic        rst_i     = 1'b1;
  logic        en_i      = 1'b0;
  logic [23:0] step_i    = '0;
  logic        rs_val_i  = 1'b0;
  logic [15:0] rs_data_i = '0;
  logic        m_ready_i = 1'b0;
  logic        rs_req_o;
  logic [15:0] m_data_o;
  logic        m_valid_o;
  logic [4:0]  fill_o;
  logic [2:0]  err_flg_o;
  logic [31:0] miss_cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 3;
  int n_req = 0;
  int n_pop = 0;
  int last_req = 0;
  bit skip_next = 1'b0;
  int due_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] next_data = 16'h0100;

  always #5 clk_i = ~clk_i;

  fir_resampler_drain #(
    .DATA_WIDTH(16),
    .ACC_WIDTH (24),
    .FIFO_DEPTH(16),
    .TIMEOUT   (64)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .step_i    (step_i),
    .rs_req_o  (rs_req_o),
    .rs_data_i (rs_data_i),
    .rs_val_i  (rs_val_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .fill_o    (fill_o),
    .err_flg_o (err_flg_o),
    .miss_cnt_o(miss_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: judge the pop the coming rising edge performs,
  // then advance one cycle, observe requests and drive any response that is due.
  task automatic step_cycle();
    if (m_valid_o && m_ready_i) begin
      n_pop++;
      if (exp_q.size() == 0) chk("sb_unexpected", 32'(m_data_o), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(m_data_o), 32'(exp_q.pop_front()));
    end
    @(negedge clk_i);
    cyc++;
    if (rs_req_o) begin
      n_req++;
      last_req = cyc;
      if (skip_next) skip_next = 1'b0;
      else due_q.push_back(cyc + lat);
    end
    rs_val_i = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      rs_val_i  = 1'b1;
      rs_data_i = next_data;
      exp_q.push_back(next_data);
      next_data += 16'h0137;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; en_i = 1'b0; rs_val_i = 1'b0; m_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    due_q.delete(); exp_q.delete();
    skip_next = 1'b0; n_req = 0; n_pop = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int prev;
    int p0;
    int r0;
    bit got;
    logic [31:0] m0;

    @(negedge clk_i);
    chk("rst_req", 32'(rs_req_o), 0);
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_data", 32'(m_data_o), 0);
    chk("rst_fill", 32'(fill_o), 0);
    chk("rst_err", 32'(err_flg_o), 0);
    chk("rst_miss", miss_cnt_o, 0);
    do_reset();

    // Unsolicited sample while IDLE
    rs_val_i = 1'b1; rs_data_i = 16'h1234; exp_q.push_back(16'h1234);
    step_cycle();
    chk("unsol_err", 32'(err_flg_o), 32'h4);
    chk("unsol_valid", 32'(m_valid_o), 1);
    chk("unsol_data", 32'(m_data_o), 32'h1234);
    m_ready_i = 1'b1;
    step_cycle();
    chk("unsol_fill", 32'(fill_o), 0);

    // Rate 1/4, latency 3, always ready
    do_reset();
    lat = 3; step_i = 24'h40_0000; m_ready_i = 1'b1; en_i = 1'b1; prev = 0;
    for (int i = 0; i < 1000 && n_pop < 100; i++) begin
      step_cycle();
      if (rs_req_o) begin
        if (prev != 0) chk("req_period", cyc - prev, 4);
        prev = cyc;
      end
    end
    chk("stream_count", n_pop, 100);
    chk("stream_err", 32'(err_flg_o), 0);

    // Backpressure until full, then missed ticks
    do_reset();
    lat = 3; step_i = 24'h80_0000; m_ready_i = 1'b0; en_i = 1'b1;
    repeat (60) step_cycle();
    chk("full_reqs", n_req, 16);
    chk("full_fill", 32'(fill_o), 16);
    chk("full_err", 32'(err_flg_o), 32'h1);
    m0 = miss_cnt_o;
    repeat (10) step_cycle();
`ifdef FIR_RESAMPLER_DRAIN_STAT_EN
    chk("miss_delta", miss_cnt_o - m0, 5);
`else
    chk("miss_zero", miss_cnt_o, 0);
`endif
    en_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 100 && n_pop < 16; i++) step_cycle();
    chk("full_drained", n_pop, 16);
    chk("full_fill_end", 32'(fill_o), 0);

    // One request never answered
    do_reset();
    lat = 3; step_i = 24'h02_0000; m_ready_i = 1'b1; skip_next = 1'b1; en_i = 1'b1; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step_cycle();
      if (err_flg_o[1]) got = 1'b1;
    end
    chk("to_seen", 32'(got), 1);
    chk("to_delay", cyc - last_req, 64);
    chk("to_err", 32'(err_flg_o), 32'h2);
    rs_val_i = 1'b1; rs_data_i = 16'h0BEE; exp_q.push_back(16'h0BEE);
    step_cycle();
    chk("to_cleared", 32'(err_flg_o), 32'h6);
    p0 = n_pop;
    for (int i = 0; i < 300 && n_pop < p0 + 2; i++) step_cycle();
    chk("to_resume", n_pop - p0, 2);
    chk("to_err_end", 32'(err_flg_o), 32'h6);

    // Disable with two requests outstanding
    do_reset();
    lat = 6; step_i = 24'h80_0000; m_ready_i = 1'b1; en_i = 1'b1;
    for (int i = 0; i < 50 && n_req < 2; i++) step_cycle();
    en_i = 1'b0; r0 = n_req;
    repeat (30) step_cycle();
    chk("drain_reqs", n_req, 2);
    chk("drain_no_new", n_req - r0, 0);
    chk("drain_pops", n_pop, 2);
    chk("drain_err", 32'(err_flg_o), 0);
    rs_val_i = 1'b1; rs_data_i = 16'h0D0D; exp_q.push_back(16'h0D0D);
    step_cycle();
    chk("drain_idle_unsol", 32'(err_flg_o), 32'h4);

    // Reset mid-traffic, late responses are unsolicited
    do_reset();
    lat = 6; step_i = 24'h80_0000; m_ready_i = 1'b0; en_i = 1'b1; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step_cycle();
      if (fill_o == 5 && due_q.size() == 3) got = 1'b1;
    end
    chk("mid_setup", 32'(got), 1);
    #1 rst_i = 1'b1; en_i = 1'b0; rs_val_i = 1'b0;
    #1;
    chk("mid_req", 32'(rs_req_o), 0);
    chk("mid_valid", 32'(m_valid_o), 0);
    chk("mid_data", 32'(m_data_o), 0);
    chk("mid_fill", 32'(fill_o), 0);
    chk("mid_err", 32'(err_flg_o), 0);
    chk("mid_miss", miss_cnt_o, 0);
    exp_q.delete();
    @(negedge clk_i);
    cyc++;
    rst_i = 1'b0;
    for (int i = 0; i < 20 && !err_flg_o[2]; i++) step_cycle();
    chk("late_err", 32'(err_flg_o), 32'h4);
    m_ready_i = 1'b1;
    repeat (20) step_cycle();
    chk("late_fill", 32'(fill_o), 0);
    chk("late_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_resampler_drain.md
FIR_RESAMPLER_DRAIN -- requirements
Module: fir_resampler_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of resampler output samples.
REQ-002 Parameter ACC_WIDTH, default 24: width of the request phase accumulator.
REQ-003 Parameter FIFO_DEPTH, default 16, power of two ≥4: output buffer depth.
REQ-004 Parameter TIMEOUT, default 64: maximum cycles from a request to its matching sample.
REQ-005 Port clk_i, input, 1: single clock; all logic rising-edge.
REQ-006 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 Port en_i, input, 1: run enable.
REQ-008 Port step_i, input, ACC_WIDTH: phase increment; request rate = step_i/2^ACC_WIDTH per clock.
REQ-009 Port rs_req_o, output, 1: one-cycle request pulse to the resampler's data_req_i.
REQ-010 Port rs_data_i, input, DATA_WIDTH signed: resampler data_o.
REQ-011 Port rs_val_i, input, 1: resampler data_val_o.
REQ-012 Port m_data_o / m_valid_o / m_ready_i, DATA_WIDTH / 1 / 1: downstream valid-ready stream.
REQ-013 Port fill_o, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-014 Port err_flg_o, output, 3: sticky errors {unsolicited, timeout, missed}.
REQ-015 Port miss_cnt_o, output, 32: missed-request count (see Configuration).

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN when en_i=1; RUN->DRAIN when en_i=0; DRAIN->IDLE when outstanding=0; DRAIN->RUN when en_i=1.
REQ-017 In RUN each cycle acc <= acc + step_i mod 2^ACC_WIDTH; carry-out is a tick; acc SHALL hold in IDLE and DRAIN and clear to 0 on IDLE->RUN.
REQ-018 Credit = FIFO_DEPTH − fill − outstanding; a tick with credit>0 SHALL produce rs_req_o=1 in the following cycle and increment outstanding.
REQ-019 A tick with credit=0 SHALL produce no request and set err_flg_o[0] (missed).
REQ-020 rs_req_o SHALL never be high two consecutive cycles from one tick and never high outside RUN.
REQ-021 rs_val_i=1 with outstanding>0 SHALL write rs_data_i into the FIFO and decrement outstanding; same-cycle request and response SHALL leave outstanding unchanged.
REQ-022 rs_val_i=1 with outstanding=0 SHALL set err_flg_o[2]; the sample is written if fill<FIFO_DEPTH, else dropped.
REQ-023 A watchdog counts cycles while outstanding>0 without rs_val_i, restarting on each rs_val_i; on reaching TIMEOUT it SHALL set err_flg_o[1] and clear outstanding to 0.
REQ-024 FIFO is first-word-fall-through; a sample written in cycle n SHALL appear on m_data_o with m_valid_o=1 in cycle n+1 when the FIFO was empty.
REQ-025 Pop occurs when m_valid_o & m_ready_i; simultaneous push and pop at full or empty SHALL both succeed and leave fill unchanged.
REQ-026 m_data_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; fill_o SHALL reach FIFO_DEPTH exactly when full.
REQ-028 err_flg_o bits SHALL clear only on reset.

Reset
REQ-029 On rst_i=1, asynchronously: state IDLE, acc=0, outstanding=0, watchdog=0, FIFO empty, rs_req_o=0, m_valid_o=0, m_data_o=0, fill_o=0, err_flg_o=0, miss_cnt_o=0.
REQ-030 Reset asserted mid-request SHALL discard outstanding requests; samples arriving after release SHALL count as unsolicited.

Configuration
REQ-031 Macro FIR_RESAMPLER_DRAIN_STAT_EN defined: miss_cnt_o SHALL increment (saturating at 2^32−1) on every missed tick.
REQ-032 Macro undefined: miss_cnt_o SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-033 step_i=2^22 (rate 1/4), resampler model answering in 3 cycles, m_ready_i=1 -> rs_req_o every 4th cycle, 100 samples out in order, err_flg_o=0.
REQ-034 FIFO_DEPTH=16, step_i=2^23, m_ready_i=0 -> exactly 16 requests, fill_o=16, then err_flg_o[0]=1; with STAT_EN miss_cnt_o counts every further tick.
REQ-035 Model never answers one request, TIMEOUT=64 -> err_flg_o[1]=1 at cycle 64 after the request, outstanding=0, subsequent requests resume.
REQ-036 rs_val_i pulse while IDLE with data 0x1234 -> err_flg_o[2]=1, m_data_o=0x1234 with m_valid_o=1 next cycle.
REQ-037 en_i dropped with 2 requests outstanding -> state DRAIN, no new rs_req_o, both samples accepted, IDLE after second rs_val_i.
REQ-038 rst_i pulsed with 3 outstanding and fill_o=5 -> all outputs at reset values within the same cycle; late rs_val_i sets err_flg_o[2].
